// File: rtl/pipeline_issue_ctrl.sv
// Issue controller for a pipeline_stage chain: round-robin address arbitration,
// in-flight ID tracking, and a fixed-length flush/drain sequence.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 8
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 3
`endif

module pipeline_issue_ctrl #(
    parameter int NUM_REQ    = 4,
    parameter int PIPE_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ*`ADDRESS_WIDTH-1:0]   req_address,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic                                ext_stall,
    input  logic                                flush_req,
    input  logic [`ID_WIDTH-1:0]                flush_req_id,
    input  logic                                retire_valid,
    input  logic [`ID_WIDTH-1:0]                retire_id,
    output logic                                issue_valid,
    output logic [`ADDRESS_WIDTH-1:0]           issue_address,
    output logic [`ID_WIDTH-1:0]                issue_id,
    output logic                                stall,
    output logic                                flush,
    output logic [`ID_WIDTH-1:0]                flush_id,
    output logic [`ID_WIDTH:0]                  inflight_count,
    output logic                                busy
);
    localparam int AW  = `ADDRESS_WIDTH;
    localparam int IW  = `ID_WIDTH;
    localparam int NID = 1 << IW;
    localparam int LGW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW  = $clog2(PIPE_DEPTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]  next_id_q, next_id_d;
    logic [LGW-1:0] last_grant_q, last_grant_d;
    logic [NID-1:0] bitmap_q, bitmap_d;
    logic [IW:0]    count_q, count_d;
    logic           ival_q, ival_d;
    logic [AW-1:0]  iaddr_q, iaddr_d;
    logic [IW-1:0]  iid_q, iid_d;
    logic           flush_q, flush_d;
    logic [IW-1:0]  fid_q, fid_d;

    logic           sel_found;
    logic [LGW-1:0] sel_idx;
    logic [LGW-1:0] cand;
    logic           grant;
    logic           flush_start;
    logic           flush_done;
    logic [AW-1:0]  addr_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
        assign addr_arr[g] = req_address[g*AW +: AW];
    end

    assign stall       = ext_stall | (state_q == S_FLUSH);
    assign busy        = (state_q != S_IDLE);
    assign flush_start = (state_q == S_IDLE) & flush_req;
    assign flush_done  = (state_q == S_FLUSH) & (cnt_q == '0);

    // Round-robin search begins one past the most recent winner.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = LGW'((int'(last_grant_q) + k) % NUM_REQ);
            if (!sel_found && req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // A pending flush outranks any request; an in-flight next_id blocks issue.
    assign grant = reset & (state_q == S_IDLE) & ~stall & ~flush_req &
                   sel_found & ~bitmap_q[next_id_q];

    assign req_ready = grant ? (NUM_REQ'(1) << sel_idx) : '0;

    always_comb begin
        ival_d  = ival_q;
        iaddr_d = iaddr_q;
        iid_d   = iid_q;
        if (grant) begin
            ival_d  = 1'b1;
            iaddr_d = addr_arr[sel_idx];
            iid_d   = next_id_q;
        end else if (!stall) begin
            ival_d  = 1'b0;
        end
        if (flush_start && (iid_q == flush_req_id))
            ival_d = 1'b0;
    end

    assign next_id_d    = grant ? next_id_q + IW'(1) : next_id_q;
    assign last_grant_d = grant ? sel_idx : last_grant_q;

    // Retire and flush clears may hit the same bit; clearing is idempotent.
    always_comb begin
        bitmap_d = bitmap_q;
        if (retire_valid)
            bitmap_d[retire_id] = 1'b0;
        if (flush_done)
            bitmap_d[fid_q] = 1'b0;
        if (grant)
            bitmap_d[next_id_q] = 1'b1;
        count_d = '0;
        for (int i = 0; i < NID; i++)
            count_d = count_d + (IW+1)'(bitmap_d[i]);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flush_d = 1'b0;
        fid_d   = fid_q;
        case (state_q)
            S_IDLE: begin
                if (flush_req) begin
                    state_d = S_FLUSH;
                    cnt_d   = CW'(PIPE_DEPTH - 1);
                    flush_d = 1'b1;
                    fid_d   = flush_req_id;
                end
            end
            S_FLUSH: begin
                if (cnt_q == '0)
                    state_d = S_DRAIN;
                else
                    cnt_d = cnt_q - CW'(1);
            end
            S_DRAIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            next_id_q    <= '0;
            last_grant_q <= LGW'(NUM_REQ - 1);
            bitmap_q     <= '0;
            count_q      <= '0;
            ival_q       <= 1'b0;
            iaddr_q      <= '0;
            iid_q        <= '0;
            flush_q      <= 1'b0;
            fid_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            next_id_q    <= next_id_d;
            last_grant_q <= last_grant_d;
            bitmap_q     <= bitmap_d;
            count_q      <= count_d;
            ival_q       <= ival_d;
            iaddr_q      <= iaddr_d;
            iid_q        <= iid_d;
            flush_q      <= flush_d;
            fid_q        <= fid_d;
        end
    end

    assign issue_valid    = ival_q;
    assign issue_address  = iaddr_q;
    assign issue_id       = iid_q;
    assign flush          = flush_q;
    assign flush_id       = fid_q;
    assign inflight_count = count_q;

endmodule

// File: tb/tb_pipeline_issue_ctrl.sv
// Bench for pipeline_issue_ctrl: cycle model plus issue scoreboard.
module tb_pipeline_issue_ctrl;
    localparam int AW = 8, IW = 3, NR = 4, PD = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*AW-1:0]  req_address = '0;
    logic [NR-1:0]     req_ready;
    logic              ext_stall = 1'b0;
    logic              flush_req = 1'b0;
    logic [IW-1:0]     flush_req_id = '0;
    logic              retire_valid = 1'b0;
    logic [IW-1:0]     retire_id = '0;
    logic              issue_valid;
    logic [AW-1:0]     issue_address;
    logic [IW-1:0]     issue_id;
    logic              stall, flush, busy;
    logic [IW-1:0]     flush_id;
    logic [IW:0]       inflight_count;

    pipeline_issue_ctrl #(.NUM_REQ(NR), .PIPE_DEPTH(PD)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_address(req_address),
        .req_ready(req_ready), .ext_stall(ext_stall), .flush_req(flush_req),
        .flush_req_id(flush_req_id), .retire_valid(retire_valid), .retire_id(retire_id),
        .issue_valid(issue_valid), .issue_address(issue_address), .issue_id(issue_id),
        .stall(stall), .flush(flush), .flush_id(flush_id),
        .inflight_count(inflight_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model state
    int             m_phase, m_cnt, m_last;
    logic [IW-1:0]  m_next, m_fid, m_iid;
    logic [7:0]     m_bm;
    logic           m_ival, m_flush;
    logic [AW-1:0]  m_iaddr;
    logic [AW+IW-1:0] sb[$];
    logic [NR-1:0]  obs_ready;
    int obs_flush, obs_busy, obs_stall, obs_gnt;

    function automatic int pc(input logic [7:0] b);
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(b[i]);
        return c;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_last = NR - 1;
        m_next = '0; m_fid = '0; m_iid = '0; m_bm = '0;
        m_ival = 1'b0; m_flush = 1'b0; m_iaddr = '0;
        sb.delete();
    endtask

    task automatic rand_addr();
        for (int i = 0; i < NR; i++) req_address[i*AW +: AW] = AW'($urandom_range(0, 255));
    endtask

    // One clock: check comb/registered outputs at negedge, advance the model, pop scoreboard after the edge.
    task automatic cyc();
        logic m_stall, m_gnt, entering;
        int gidx, c;
        logic [NR-1:0] exp_ready;
        logic [AW+IW-1:0] e;
        @(negedge clk);
        m_stall = ext_stall | (m_phase == 1);
        m_gnt = 1'b0; gidx = 0;
        if (m_phase == 0 && !m_stall && !flush_req && !m_bm[m_next]) begin
            for (int k = 1; k <= NR; k++) begin
                c = (m_last + k) % NR;
                if (!m_gnt && req_valid[c]) begin m_gnt = 1'b1; gidx = c; end
            end
        end
        exp_ready = m_gnt ? (NR'(1) << gidx) : '0;
        obs_ready = req_ready;
        obs_flush += int'(flush); obs_busy += int'(busy);
        obs_stall += int'(stall); obs_gnt += int'(req_ready != '0);
        chk("stall", stall, m_stall);
        chk("req_ready", req_ready, exp_ready);
        chk("busy", busy, m_phase != 0);
        chk("flush", flush, m_flush);
        if (m_flush) chk("flush_id", flush_id, m_fid);
        chk("inflight", inflight_count, pc(m_bm));
        chk("issue_valid", issue_valid, m_ival);
        if (m_ival) begin
            chk("issue_address", issue_address, m_iaddr);
            chk("issue_id", issue_id, m_iid);
        end
        entering = (m_phase == 0) && flush_req;
        if (m_gnt) begin
            m_ival = 1'b1; m_iaddr = req_address[gidx*AW +: AW]; m_iid = m_next;
            sb.push_back({m_iaddr, m_next});
        end else if (!m_stall) m_ival = 1'b0;
        if (entering && m_iid == flush_req_id) m_ival = 1'b0;
        if (retire_valid) m_bm[retire_id] = 1'b0;
        if (m_phase == 1 && m_cnt == 1) m_bm[m_fid] = 1'b0;
        if (m_gnt) begin m_bm[m_next] = 1'b1; m_next = m_next + 1'b1; m_last = gidx; end
        m_flush = entering;
        if (entering) begin m_fid = flush_req_id; m_phase = 1; m_cnt = PD; end
        else if (m_phase == 1) begin if (m_cnt == 1) m_phase = 2; else m_cnt--; end
        else if (m_phase == 2) m_phase = 0;
        @(posedge clk); #1;
        if (m_gnt) begin
            e = sb.pop_front();
            chk("sb_address", issue_address, e[AW+IW-1:IW]);
            chk("sb_id", issue_id, e[IW-1:0]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; req_valid = '1; ext_stall = 1'b1; #1;
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_issue_address", issue_address, 0);
        chk("rst_issue_id", issue_id, 0);
        chk("rst_flush", flush, 0);
        chk("rst_flush_id", flush_id, 0);
        chk("rst_inflight", inflight_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_stall_hi", stall, 1);
        ext_stall = 1'b0; #1;
        chk("rst_stall_lo", stall, 0);
        model_reset();
        req_valid = '0; flush_req = 1'b0; retire_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        do_reset();

        // Round-robin order from reset
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) begin
            rand_addr(); cyc();
            chk("rr_order", obs_ready, 32'(1) << i);
            chk("rr_id", issue_id, i);
        end
        chk("inflight4", inflight_count, 4);

        // Flush of id 2 with requests pending and a second flush dropped
        obs_flush = 0; obs_busy = 0; obs_stall = 0; obs_gnt = 0;
        flush_req = 1'b1; flush_req_id = 3'd2; cyc();
        chk("flush_vs_grant", obs_ready, 0);
        flush_req = 1'b0; cyc();
        flush_req = 1'b1; flush_req_id = 3'd5; cyc();
        flush_req = 1'b0; cyc(); cyc();
        chk("flush_inflight", inflight_count, 3);
        cyc();
        chk("flush_pulses", obs_flush, 1);
        chk("flush_busy", obs_busy, 5);
        chk("flush_stall", obs_stall, 4);
        chk("flush_grants", obs_gnt, 0);
        rand_addr(); cyc();
        chk("post_flush_id", issue_id, 4);

        // Fill all IDs, then wrap after a retire
        do_reset();
        req_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin rand_addr(); cyc(); end
        chk("full_cnt", inflight_count, 8);
        rand_addr(); cyc();
        chk("ninth_ready", obs_ready, 0);
        req_valid = '0; retire_valid = 1'b1; retire_id = 3'd0; cyc();
        retire_valid = 1'b0;
        chk("retire_cnt", inflight_count, 7);
        req_valid = 4'hF; rand_addr(); cyc();
        chk("wrap_id", issue_id, 0);
        chk("wrap_valid", issue_valid, 1);

        // Flush the issuing ID under ext_stall; retire and flush clear collide
        req_valid = '0; ext_stall = 1'b1; flush_req = 1'b1; flush_req_id = 3'd0; cyc();
        flush_req = 1'b0; ext_stall = 1'b0;
        chk("flush_kill_valid", issue_valid, 0);
        cyc(); cyc(); cyc();
        retire_valid = 1'b1; retire_id = 3'd0; cyc();
        retire_valid = 1'b0;
        chk("dual_clear", inflight_count, 7);
        cyc();
        retire_valid = 1'b1; retire_id = 3'd0; cyc();
        retire_valid = 1'b0;
        chk("stale_retire", inflight_count, 7);

        // Reset mid-FLUSH aborts it
        flush_req = 1'b1; flush_req_id = 3'd3; cyc();
        flush_req = 1'b0;
        chk("pre_abort_flush", flush, 1);
        do_reset();

        // Stall hold of the first grant after reset
        req_address = '0; req_address[0 +: AW] = 8'h10; req_valid = 4'b0001; cyc();
        chk("g10_addr", issue_address, 8'h10);
        chk("g10_id", issue_id, 0);
        req_valid = 4'hF; ext_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hold_valid", issue_valid, 1);
            chk("hold_addr", issue_address, 8'h10);
            chk("hold_id", issue_id, 0);
            chk("hold_ready", obs_ready, 0);
        end
        ext_stall = 1'b0; req_valid = '0; cyc(); cyc();
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
